dcache_mem_responder: RTL and testbench

Memory-side responder for the data cache's controller interface. It accepts per-consumer read and write requests from dcache, arbitrates them onto NUM_CHANNELS external memory channels, and returns ready and data to dcache. It sits between dcache and the global memory model or arbiter.

---
 rtl/dcache_pkg.sv | 19 +
 rtl/mem_channel_fsm.sv | 147 ++++++++++++++
 rtl/dcache_mem_responder.sv | 148 ++++++++++++++
 tb/tb_dcache_mem_responder.sv | 418 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared types and sizing helpers for the dcache memory-side responder.
package dcache_pkg;

  typedef enum logic [2:0] {
    StIdle       = 3'd0,
    StReadWait   = 3'd1,
    StWriteWait  = 3'd2,
    StReadRelay  = 3'd3,
    StWriteRelay = 3'd4
  } channel_state_t;

  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned NumConsumersDefault = 8;
  localparam int unsigned ConsumerIdBits      = id_width(NumConsumersDefault);

endpackage

// File: rtl/mem_channel_fsm.sv
// One memory channel: takes a grant from the top-level chain, runs the mem-side
// handshake and relays ready/data back to the granted consumer.
module mem_channel_fsm
  import dcache_pkg::*;
#(
  parameter int unsigned ADDR_BITS     = 8,
  parameter int unsigned DATA_BITS     = 8,
  parameter int unsigned NUM_CONSUMERS = 8,
  parameter int unsigned ID_BITS       = ConsumerIdBits
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 grant_i,
  input  logic [ID_BITS-1:0]   grant_id_i,
  input  logic                 grant_read_i,
  input  logic [ADDR_BITS-1:0] grant_addr_i,
  input  logic [DATA_BITS-1:0] grant_wdata_i,
  input  logic                 cons_read_valid_i,
  input  logic                 cons_write_valid_i,
  output logic                 idle_o,
  output logic                 release_o,
  output logic [ID_BITS-1:0]   id_o,
  output logic [ID_BITS-1:0]   ptr_o,
  output logic                 mem_read_valid_o,
  output logic [ADDR_BITS-1:0] mem_read_address_o,
  input  logic                 mem_read_ready_i,
  input  logic [DATA_BITS-1:0] mem_read_data_i,
  output logic                 mem_write_valid_o,
  output logic [ADDR_BITS-1:0] mem_write_address_o,
  output logic [DATA_BITS-1:0] mem_write_data_o,
  input  logic                 mem_write_ready_i,
  output logic                 cons_read_ready_o,
  output logic [DATA_BITS-1:0] cons_read_data_o,
  output logic                 cons_write_ready_o
);

  channel_state_t       state_q, state_d;
  logic [ID_BITS-1:0]   id_q, id_d, ptr_q, ptr_d;
  logic                 rvalid_q, rvalid_d, wvalid_q, wvalid_d;
  logic [ADDR_BITS-1:0] raddr_q, raddr_d, waddr_q, waddr_d;
  logic [DATA_BITS-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic                 rready_q, rready_d, wready_q, wready_d;

  always_comb begin
    state_d   = state_q;
    id_d      = id_q;
    ptr_d     = ptr_q;
    rvalid_d  = rvalid_q;
    wvalid_d  = wvalid_q;
    raddr_d   = raddr_q;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    rready_d  = rready_q;
    wready_d  = wready_q;
    release_o = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (grant_i) begin
          id_d  = grant_id_i;
          ptr_d = (grant_id_i == ID_BITS'(NUM_CONSUMERS - 1)) ? '0 : grant_id_i + 1'b1;
          if (grant_read_i) begin
            rvalid_d = 1'b1;
            raddr_d  = grant_addr_i;
            state_d  = StReadWait;
          end else begin
            wvalid_d = 1'b1;
            waddr_d  = grant_addr_i;
            wdata_d  = grant_wdata_i;
            state_d  = StWriteWait;
          end
        end
      end
      StReadWait: begin
        if (mem_read_ready_i) begin
          rvalid_d = 1'b0;
          rdata_d  = mem_read_data_i;
          rready_d = 1'b1;
          state_d  = StReadRelay;
        end
      end
      StWriteWait: begin
        if (mem_write_ready_i) begin
          wvalid_d = 1'b0;
          wready_d = 1'b1;
          state_d  = StWriteRelay;
        end
      end
      StReadRelay: begin
        if (!cons_read_valid_i) begin
          rready_d  = 1'b0;
          release_o = 1'b1;
          state_d   = StIdle;
        end
      end
      StWriteRelay: begin
        if (!cons_write_valid_i) begin
          wready_d  = 1'b0;
          release_o = 1'b1;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      id_q     <= '0;
      ptr_q    <= '0;
      rvalid_q <= 1'b0;
      wvalid_q <= 1'b0;
      raddr_q  <= '0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      rready_q <= 1'b0;
      wready_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      id_q     <= id_d;
      ptr_q    <= ptr_d;
      rvalid_q <= rvalid_d;
      wvalid_q <= wvalid_d;
      raddr_q  <= raddr_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      rready_q <= rready_d;
      wready_q <= wready_d;
    end
  end

  assign idle_o              = (state_q == StIdle);
  assign id_o                = id_q;
  assign ptr_o               = ptr_q;
  assign mem_read_valid_o    = rvalid_q;
  assign mem_read_address_o  = raddr_q;
  assign mem_write_valid_o   = wvalid_q;
  assign mem_write_address_o = waddr_q;
  assign mem_write_data_o    = wdata_q;
  assign cons_read_ready_o   = rready_q;
  assign cons_read_data_o    = rdata_q;
  assign cons_write_ready_o  = wready_q;

endmodule

// File: rtl/dcache_mem_responder.sv
// Arbitrates per-consumer dcache requests onto NUM_CHANNELS memory channels and
// merges channel responses back onto the consumer ports.
module dcache_mem_responder
  import dcache_pkg::*;
#(
  parameter int unsigned ADDR_BITS     = 8,
  parameter int unsigned DATA_BITS     = 8,
  parameter int unsigned NUM_CONSUMERS = 8,
  parameter int unsigned NUM_CHANNELS  = 4
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic [NUM_CONSUMERS-1:0]                 consumer_read_valid,
  input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0]  consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]                 consumer_read_ready,
  output logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]  consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]                 consumer_write_valid,
  input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0]  consumer_write_address,
  input  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]  consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]                 consumer_write_ready,
  output logic [NUM_CHANNELS-1:0]                  mem_read_valid,
  output logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]   mem_read_address,
  input  logic [NUM_CHANNELS-1:0]                  mem_read_ready,
  input  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]   mem_read_data,
  output logic [NUM_CHANNELS-1:0]                  mem_write_valid,
  output logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]   mem_write_address,
  output logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]   mem_write_data,
  input  logic [NUM_CHANNELS-1:0]                  mem_write_ready
);

  localparam int unsigned IdBits = id_width(NUM_CONSUMERS);

  logic [NUM_CHANNELS-1:0]                ch_idle, ch_release, ch_grant, ch_grant_read;
  logic [NUM_CHANNELS-1:0]                ch_rready, ch_wready, ch_cons_rv, ch_cons_wv;
  logic [NUM_CHANNELS-1:0][IdBits-1:0]    ch_id, ch_ptr, ch_gid;
  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] ch_gaddr;
  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] ch_gdata, ch_rdata;

  logic [NUM_CONSUMERS-1:0]                claimed_q, claimed_d, taken, released, req;
  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] rdata_q, rdata_d, merged;

  assign req = consumer_read_valid | consumer_write_valid;

  // Grant chain: lower-index channels claim first, so channel 0 wins same-cycle conflicts.
  always_comb begin
    int          idx;
    logic [IdBits-1:0] cand;
    idx           = 0;
    cand          = '0;
    taken         = '0;
    ch_grant      = '0;
    ch_grant_read = '0;
    ch_gid        = '0;
    ch_gaddr      = '0;
    ch_gdata      = '0;
    for (int c = 0; c < int'(NUM_CHANNELS); c++) begin
      if (ch_idle[c]) begin
        for (int k = 0; k < int'(NUM_CONSUMERS); k++) begin
          idx = int'(ch_ptr[c]) + k;
          if (idx >= int'(NUM_CONSUMERS)) idx = idx - int'(NUM_CONSUMERS);
          cand = IdBits'(idx);
          if (!ch_grant[c] && req[cand] && !claimed_q[cand] && !taken[cand]) begin
            ch_grant[c] = 1'b1;
            ch_gid[c]   = cand;
          end
        end
        if (ch_grant[c]) begin
          taken[ch_gid[c]] = 1'b1;
          ch_grant_read[c] = consumer_read_valid[ch_gid[c]];
          ch_gaddr[c]      = ch_grant_read[c] ? consumer_read_address[ch_gid[c]]
                                              : consumer_write_address[ch_gid[c]];
          ch_gdata[c]      = consumer_write_data[ch_gid[c]];
        end
      end
    end
  end

  always_comb begin
    released             = '0;
    merged               = '0;
    consumer_read_ready  = '0;
    consumer_write_ready = '0;
    ch_cons_rv           = '0;
    ch_cons_wv           = '0;
    for (int c = 0; c < int'(NUM_CHANNELS); c++) begin
      ch_cons_rv[c] = consumer_read_valid[ch_id[c]];
      ch_cons_wv[c] = consumer_write_valid[ch_id[c]];
      if (ch_release[c]) released[ch_id[c]] = 1'b1;
      if (ch_rready[c]) begin
        consumer_read_ready[ch_id[c]] = 1'b1;
        merged[ch_id[c]]              = merged[ch_id[c]] | ch_rdata[c];
      end
      if (ch_wready[c]) consumer_write_ready[ch_id[c]] = 1'b1;
    end
    claimed_d = (claimed_q & ~released) | taken;
    // Read data holds its last value once the relaying channel lets go.
    for (int i = 0; i < int'(NUM_CONSUMERS); i++) begin
      rdata_d[i] = consumer_read_ready[i] ? merged[i] : rdata_q[i];
    end
  end

  assign consumer_read_data = rdata_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      claimed_q <= '0;
      rdata_q   <= '0;
    end else begin
      claimed_q <= claimed_d;
      rdata_q   <= rdata_d;
    end
  end

  for (genvar c = 0; c < int'(NUM_CHANNELS); c++) begin : g_ch
    mem_channel_fsm #(
      .ADDR_BITS    (ADDR_BITS),
      .DATA_BITS    (DATA_BITS),
      .NUM_CONSUMERS(NUM_CONSUMERS),
      .ID_BITS      (IdBits)
    ) u_fsm (
      .clk                (clk),
      .reset              (reset),
      .grant_i            (ch_grant[c]),
      .grant_id_i         (ch_gid[c]),
      .grant_read_i       (ch_grant_read[c]),
      .grant_addr_i       (ch_gaddr[c]),
      .grant_wdata_i      (ch_gdata[c]),
      .cons_read_valid_i  (ch_cons_rv[c]),
      .cons_write_valid_i (ch_cons_wv[c]),
      .idle_o             (ch_idle[c]),
      .release_o          (ch_release[c]),
      .id_o               (ch_id[c]),
      .ptr_o              (ch_ptr[c]),
      .mem_read_valid_o   (mem_read_valid[c]),
      .mem_read_address_o (mem_read_address[c]),
      .mem_read_ready_i   (mem_read_ready[c]),
      .mem_read_data_i    (mem_read_data[c]),
      .mem_write_valid_o  (mem_write_valid[c]),
      .mem_write_address_o(mem_write_address[c]),
      .mem_write_data_o   (mem_write_data[c]),
      .mem_write_ready_i  (mem_write_ready[c]),
      .cons_read_ready_o  (ch_rready[c]),
      .cons_read_data_o   (ch_rdata[c]),
      .cons_write_ready_o (ch_wready[c])
    );
  end

endmodule

// File: tb/tb_dcache_mem_responder.sv
// Bench for dcache_mem_responder: directed scenarios plus randomized per-port traffic
// checked against a simple array model of memory.
module tb_dcache_mem_responder;

  localparam int NC  = 8;
  localparam int NCH = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [NC-1:0]             consumer_read_valid, consumer_read_ready;
  logic [NC-1:0][7:0]        consumer_read_address, consumer_read_data;
  logic [NC-1:0]             consumer_write_valid, consumer_write_ready;
  logic [NC-1:0][7:0]        consumer_write_address, consumer_write_data;
  logic [NCH-1:0]            mem_read_valid, mem_read_ready, mem_write_valid, mem_write_ready;
  logic [NCH-1:0][7:0]       mem_read_address, mem_read_data;
  logic [NCH-1:0][7:0]       mem_write_address, mem_write_data;

  logic       rv [NC];
  logic       wv [NC];
  logic [7:0] ra [NC];
  logic [7:0] wa [NC];
  logic [7:0] wd [NC];

  always_comb begin
    for (int i = 0; i < NC; i++) begin
      consumer_read_valid[i]    = rv[i];
      consumer_read_address[i]  = ra[i];
      consumer_write_valid[i]   = wv[i];
      consumer_write_address[i] = wa[i];
      consumer_write_data[i]    = wd[i];
    end
  end

  dcache_mem_responder #(
    .ADDR_BITS    (8),
    .DATA_BITS    (8),
    .NUM_CONSUMERS(NC),
    .NUM_CHANNELS (NCH)
  ) dut (
    .clk                   (clk),
    .reset                 (reset),
    .consumer_read_valid   (consumer_read_valid),
    .consumer_read_address (consumer_read_address),
    .consumer_read_ready   (consumer_read_ready),
    .consumer_read_data    (consumer_read_data),
    .consumer_write_valid  (consumer_write_valid),
    .consumer_write_address(consumer_write_address),
    .consumer_write_data   (consumer_write_data),
    .consumer_write_ready  (consumer_write_ready),
    .mem_read_valid        (mem_read_valid),
    .mem_read_address      (mem_read_address),
    .mem_read_ready        (mem_read_ready),
    .mem_read_data         (mem_read_data),
    .mem_write_valid       (mem_write_valid),
    .mem_write_address     (mem_write_address),
    .mem_write_data        (mem_write_data),
    .mem_write_ready       (mem_write_ready)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Memory model: tb_mem is what the channels see; ref_mem is the consumers' expectation.
  logic [7:0] tb_mem  [256];
  logic [7:0] ref_mem [256];
  int  mem_lat = 1;
  bit  mem_rand = 1'b0;
  bit  dup_chk = 1'b0;
  int  mem_reads = 0, mem_writes = 0, max_busy = 0, dup_err = 0;
  int  issued_reads = 0, issued_writes = 0;
  int  rcnt [NCH];
  int  wcnt [NCH];

  function automatic int lat_pick();
    return mem_rand ? int'($urandom_range(0, 3)) : mem_lat;
  endfunction

  initial begin
    int busy;
    logic [7:0] tag_a, tag_b;
    mem_read_ready  = '0;
    mem_read_data   = '0;
    mem_write_ready = '0;
    for (int c = 0; c < NCH; c++) begin
      rcnt[c] = 1;
      wcnt[c] = 1;
    end
    forever begin
      @(negedge clk);
      busy = 0;
      for (int c = 0; c < NCH; c++) begin
        if (mem_read_ready[c]) begin
          if (!mem_read_valid[c]) begin
            mem_read_ready[c] = 1'b0;
            rcnt[c] = lat_pick();
          end
        end else if (mem_read_valid[c]) begin
          if (rcnt[c] == 0) begin
            mem_read_ready[c] = 1'b1;
            mem_read_data[c]  = tb_mem[mem_read_address[c]];
            mem_reads++;
          end else rcnt[c]--;
        end else rcnt[c] = lat_pick();
        if (mem_write_ready[c]) begin
          if (!mem_write_valid[c]) begin
            mem_write_ready[c] = 1'b0;
            wcnt[c] = lat_pick();
          end
        end else if (mem_write_valid[c]) begin
          if (wcnt[c] == 0) begin
            mem_write_ready[c] = 1'b1;
            tb_mem[mem_write_address[c]] = mem_write_data[c];
            mem_writes++;
          end else wcnt[c]--;
        end else wcnt[c] = lat_pick();
        if (mem_read_valid[c] || mem_write_valid[c]) busy++;
      end
      if (busy > max_busy) max_busy = busy;
      // In the random phase each port owns address[7:5]; two live channels with one tag is a double grant.
      if (dup_chk) begin
        for (int a = 0; a < NCH; a++) begin
          for (int b = a + 1; b < NCH; b++) begin
            if ((mem_read_valid[a] || mem_write_valid[a]) &&
                (mem_read_valid[b] || mem_write_valid[b])) begin
              tag_a = mem_read_valid[a] ? mem_read_address[a] : mem_write_address[a];
              tag_b = mem_read_valid[b] ? mem_read_address[b] : mem_write_address[b];
              if (tag_a[7:5] == tag_b[7:5]) dup_err++;
            end
          end
        end
      end
    end
  end

  task automatic do_read(input int p, input logic [7:0] a, output logic [7:0] d);
    int n;
    ra[p] = a;
    rv[p] = 1'b1;
    n = 0;
    while (!consumer_read_ready[p] && n < 300) begin
      tick();
      n++;
    end
    check_eq("rd_ready", 32'(consumer_read_ready[p]), 1);
    d = consumer_read_data[p];
    rv[p] = 1'b0;
    n = 0;
    while (consumer_read_ready[p] && n < 10) begin
      tick();
      n++;
    end
  endtask

  task automatic do_write(input int p, input logic [7:0] a, input logic [7:0] dat);
    int n;
    wa[p] = a;
    wd[p] = dat;
    wv[p] = 1'b1;
    n = 0;
    while (!consumer_write_ready[p] && n < 300) begin
      tick();
      n++;
    end
    check_eq("wr_ready", 32'(consumer_write_ready[p]), 1);
    wv[p] = 1'b0;
    n = 0;
    while (consumer_write_ready[p] && n < 10) begin
      tick();
      n++;
    end
  endtask

  // Read and write presented together; read must complete before the write is acknowledged.
  task automatic do_both(input int p, input logic [7:0] rda, input logic [7:0] wra,
                         input logic [7:0] dat, output logic [7:0] d, output bit order_ok);
    int n;
    ra[p] = rda;
    wa[p] = wra;
    wd[p] = dat;
    rv[p] = 1'b1;
    wv[p] = 1'b1;
    order_ok = 1'b1;
    n = 0;
    while (!consumer_read_ready[p] && n < 300) begin
      tick();
      if (consumer_write_ready[p]) order_ok = 1'b0;
      n++;
    end
    check_eq("both_rd_ready", 32'(consumer_read_ready[p]), 1);
    d = consumer_read_data[p];
    rv[p] = 1'b0;
    n = 0;
    while (!consumer_write_ready[p] && n < 300) begin
      tick();
      n++;
    end
    check_eq("both_wr_ready", 32'(consumer_write_ready[p]), 1);
    wv[p] = 1'b0;
    n = 0;
    while ((consumer_write_ready[p] || consumer_read_ready[p]) && n < 10) begin
      tick();
      n++;
    end
  endtask

  task automatic ovs_port(input int p);
    logic [7:0] d;
    logic [7:0] a;
    a = 8'(p);
    do_read(p, a, d);
    check_eq("ovs_data", 32'(d), 32'(ref_mem[a]));
  endtask

  task automatic port_run(input int p, input int nops);
    logic [2:0] pt;
    logic [7:0] a, dat, d;
    bit ok;
    int op;
    pt = 3'(p);
    for (int i = 0; i < nops; i++) begin
      op  = int'($urandom_range(0, 2));
      a   = {pt, 5'($urandom)};
      dat = 8'($urandom);
      if (op == 0) begin
        issued_reads++;
        do_read(p, a, d);
        check_eq("rand_rd_data", 32'(d), 32'(ref_mem[a]));
      end else if (op == 1) begin
        issued_writes++;
        do_write(p, a, dat);
        ref_mem[a] = dat;
      end else begin
        issued_reads++;
        issued_writes++;
        do_both(p, a, a, dat, d, ok);
        check_eq("rand_both_old", 32'(d), 32'(ref_mem[a]));
        check_eq("rand_both_order", 32'(ok), 1);
        ref_mem[a] = dat;
      end
      repeat ($urandom_range(0, 2)) tick();
    end
  endtask

  initial begin
    logic [7:0] d;
    bit ok;
    int n, r0, w0, mism;
    for (int i = 0; i < NC; i++) begin
      rv[i] = 1'b1;
      wv[i] = 1'b0;
      ra[i] = 8'(i);
      wa[i] = '0;
      wd[i] = '0;
    end
    for (int a = 0; a < 256; a++) begin
      tb_mem[a]  = 8'($urandom);
      ref_mem[a] = tb_mem[a];
    end

    // Reset held with every read valid asserted.
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      tick();
      check_eq("rst_ctl", 32'({mem_read_valid, mem_write_valid,
                               consumer_read_ready, consumer_write_ready}), 0);
      check_eq("rst_data", 32'(|{consumer_read_data, mem_read_address,
                                 mem_write_address, mem_write_data}), 0);
    end
    reset = 1'b0;
    for (int i = 0; i < NC; i++) rv[i] = 1'b0;
    tick();
    check_eq("rst_release", 32'({mem_read_valid, mem_write_valid,
                                 consumer_read_ready, consumer_write_ready}), 0);

    // Single read, port 3.
    mem_lat = 4;
    tb_mem[8'h2A]  = 8'h5C;
    ref_mem[8'h2A] = 8'h5C;
    tick();
    ra[3] = 8'h2A;
    rv[3] = 1'b1;
    tick();
    check_eq("rd_mvalid", 32'(mem_read_valid), 32'h1);
    check_eq("rd_maddr", 32'(mem_read_address[0]), 32'h2A);
    n = 0;
    while (!mem_read_ready[0] && n < 20) begin
      tick();
      n++;
    end
    check_eq("rd_cready_early", 32'(consumer_read_ready), 0);
    tick();
    check_eq("rd_cready", 32'(consumer_read_ready), 32'h08);
    check_eq("rd_cdata", 32'(consumer_read_data[3]), 32'h5C);
    check_eq("rd_mvalid_drop", 32'(mem_read_valid), 0);
    rv[3] = 1'b0;
    tick();
    check_eq("rd_cready_clr", 32'(consumer_read_ready), 0);

    // Single write, port 5.
    tick();
    wa[5] = 8'h10;
    wd[5] = 8'h77;
    wv[5] = 1'b1;
    tick();
    check_eq("wr_mvalid", 32'(mem_write_valid), 32'h1);
    check_eq("wr_maddr", 32'(mem_write_address[0]), 32'h10);
    check_eq("wr_mdata", 32'(mem_write_data[0]), 32'h77);
    n = 0;
    while (!mem_write_ready[0] && n < 20) begin
      tick();
      n++;
    end
    tick();
    check_eq("wr_cready", 32'(consumer_write_ready), 32'h20);
    wv[5] = 1'b0;
    tick();
    check_eq("wr_cready_clr", 32'(consumer_write_ready), 0);
    check_eq("wr_mem", 32'(tb_mem[8'h10]), 32'h77);
    ref_mem[8'h10] = 8'h77;

    // Oversubscription: all ports read their own index.
    mem_lat = 2;
    for (int p = 0; p < NC; p++) begin
      tb_mem[p]  = 8'(p);
      ref_mem[p] = 8'(p);
    end
    tick();
    r0 = mem_reads;
    max_busy = 0;
    for (int p = 0; p < NC; p++) begin
      automatic int pp = p;
      fork
        ovs_port(pp);
      join_none
    end
    wait fork;
    check_eq("ovs_max_busy", 32'(max_busy), NCH);
    check_eq("ovs_reads", 32'(mem_reads - r0), NC);

    // Read/write collision on port 1.
    r0 = mem_reads;
    w0 = mem_writes;
    do_both(1, 8'h01, 8'h02, 8'hAA, d, ok);
    check_eq("col_rd_data", 32'(d), 32'(ref_mem[8'h01]));
    check_eq("col_order", 32'(ok), 1);
    check_eq("col_reads", 32'(mem_reads - r0), 1);
    check_eq("col_writes", 32'(mem_writes - w0), 1);
    check_eq("col_wr_mem", 32'(tb_mem[8'h02]), 32'hAA);
    ref_mem[8'h02] = 8'hAA;

    // Reset while channel 0 waits on memory.
    mem_lat = 10;
    tick();
    ra[0] = 8'h33;
    rv[0] = 1'b1;
    tick();
    tick();
    check_eq("mrst_pending", 32'(mem_read_valid[0]), 1);
    reset = 1'b1;
    rv[0] = 1'b0;
    tick();
    check_eq("mrst_clear", 32'({mem_read_valid, mem_write_valid,
                                consumer_read_ready, consumer_write_ready}), 0);
    reset = 1'b0;
    mem_lat = 1;
    tick();
    do_read(6, 8'h44, d);
    check_eq("mrst_after", 32'(d), 32'(ref_mem[8'h44]));

    // Random traffic, each port confined to its own address slice.
    mem_rand = 1'b1;
    tick();
    dup_chk = 1'b1;
    r0 = mem_reads;
    w0 = mem_writes;
    issued_reads = 0;
    issued_writes = 0;
    for (int p = 0; p < NC; p++) begin
      automatic int pp = p;
      fork
        port_run(pp, 8);
      join_none
    end
    wait fork;
    dup_chk = 1'b0;
    check_eq("rand_mem_reads", 32'(mem_reads - r0), 32'(issued_reads));
    check_eq("rand_mem_writes", 32'(mem_writes - w0), 32'(issued_writes));
    check_eq("rand_dup_grant", 32'(dup_err), 0);
    mism = 0;
    for (int a = 0; a < 256; a++) if (tb_mem[a] !== ref_mem[a]) mism++;
    check_eq("mem_image", 32'(mism), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
